sample_reader: RTL
==================

// Module: sample_reader
// PURPOSE
//  Reads back the sample-result SRAM, one entry per hit pixel pair: {dir[31], 17'd0, addr[13:0]}.
//  Decodes each entry and re-fetches the addressed 32-bit frame word (two 16-bit pixels) from frame SRAM.
//  Streams {dir, addr, pix_a, pix_b, |a-b|} downstream over a valid/ready handshake.
//  Sits after the sampling stage: it is the reader of the SRAM that the sampling stage writes.
// PARAMETERS
//  DATAWIDTH   32    SRAM word width (sample and frame SRAM)
//  PIXWIDTH    16    pixel width; frame word = {pix_a[31:16], pix_b[15:0]}
//  ADDR        14    SRAM address width (both SRAMs)
//  CNTWIDTH    11    entry counter width
//  ENTRIES     1200  number of sample entries to read per run
//  SKIP_DUP    1     1: drop an entry whose addr equals the last emitted addr
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  enable     in   1          start request, sampled only in IDLE
//  sload      out  1          sample SRAM read strobe
//  saddr      out  ADDR       sample SRAM read address
//  sdata      in   DATAWIDTH  sample SRAM read data, valid the cycle after sload
//  fload      out  1          frame SRAM read strobe
//  faddr      out  ADDR       frame SRAM read address
//  fdata      in   DATAWIDTH  frame SRAM read data, valid the cycle after fload
//  out_valid  out  1          output beat valid
//  out_ready  in   1          downstream accepts the beat
//  out_dir    out  1          entry bit31: 1 = pix_a > pix_b
//  out_addr   out  ADDR       frame address of the hit
//  out_pix_a  out  PIXWIDTH   fdata[31:16]
//  out_pix_b  out  PIXWIDTH   fdata[15:0]
//  out_diff   out  PIXWIDTH   |pix_a - pix_b|, unsigned
//  err_cnt    out  CNTWIDTH   count of malformed entries (bits[30:14] != 0), saturating
//  done       out  1          run complete; level signal
// BEHAVIOUR
//  - Reset (async): state IDLE, every output 0, entry counter 0, last-addr valid flag cleared.
//  - FSM states:
//    - IDLE: on enable=1, go to S_RD. done=0.
//    - S_RD: sload=1, saddr=entry count. Go to S_DEC.
//    - S_DEC: register sdata.
//      - bits[30:14] != 0: err_cnt++ (saturating), skip to NEXT.
//      - SKIP_DUP=1 and addr == last emitted addr: skip to NEXT.
//      - otherwise: fload=1, faddr=sdata[13:0], go to S_FET.
//    - S_FET: register fdata and compute out_diff. Go to S_OUT.
//    - S_OUT: out_valid=1, payload held stable until out_ready=1 is sampled.
//      - Handshake completes on the edge where valid&ready are both 1. Then record last addr, go to NEXT.
//    - NEXT (same cycle, not a separate state): counter++.
//      - counter == ENTRIES-1 before increment: go to DONE. Else go to S_RD.
//    - DONE: done=1 and out_valid=0. Stay while enable=1. On enable=0, go to IDLE and clear counter.
//  - Latency: 4 cycles per emitted entry from sload to first out_valid (with out_ready tied 1). Skipped entries cost 2 cycles.
//  - out_valid never drops without a handshake. out_ready while out_valid=0 is ignored.
//  - enable is ignored outside IDLE and DONE; deasserting it mid-run does not abort the run.
//  - sload and fload are single-cycle pulses, never high together.
//  - saddr wraps are impossible: the counter stops at ENTRIES-1.
//  - out_dir is the stored bit31, passed through unchanged. It is not recomputed.
//  - out_diff = pix_a - pix_b if pix_a >= pix_b, else pix_b - pix_a. Arithmetic is PIXWIDTH bits, unsigned.
//  - Reset mid-run: immediate return to IDLE; no partial beat is held.
// TESTING
//  1. ENTRIES=4; sample SRAM = {0x80000005, 0x00000007, 0x80000009, 0x0000000A}; out_ready=1
//     -> 4 beats with addr 5,7,9,10, dir 1,0,1,0; done=1 after the last beat.
//  2. Frame word 0x1234_1000 at addr 5 -> pix_a=0x1234, pix_b=0x1000, diff=0x0234.
//     Frame word 0x1000_1234 -> diff=0x0234.
//  3. Entries 0x80000005 repeated 3x, SKIP_DUP=1 -> one beat. SKIP_DUP=0 -> three beats.
//  4. Entry 0x00020003 -> no beat, err_cnt=1. err_cnt saturates at 2^CNTWIDTH-1.
//  5. out_ready held 0 for 10 cycles -> out_valid and payload stable;
//     ready=1 for 1 cycle -> exactly one beat accepted.
//  6. Assert rst during S_OUT -> all outputs 0 at once.
//     Re-enable -> run restarts at saddr=0.

Source files
------------

// File: rtl/sample_reader.sv
// Reads back sample-result entries, re-fetches each addressed frame word and
// streams {dir, addr, pix_a, pix_b, |a-b|} over a valid/ready handshake.
module sample_reader #(
    parameter int DATAWIDTH = 32,
    parameter int PIXWIDTH  = 16,
    parameter int ADDR      = 14,
    parameter int CNTWIDTH  = 11,
    parameter int ENTRIES   = 1200,
    parameter int SKIP_DUP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 sload,
    output logic [ADDR-1:0]      saddr,
    input  logic [DATAWIDTH-1:0] sdata,
    output logic                 fload,
    output logic [ADDR-1:0]      faddr,
    input  logic [DATAWIDTH-1:0] fdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_dir,
    output logic [ADDR-1:0]      out_addr,
    output logic [PIXWIDTH-1:0]  out_pix_a,
    output logic [PIXWIDTH-1:0]  out_pix_b,
    output logic [PIXWIDTH-1:0]  out_diff,
    output logic [CNTWIDTH-1:0]  err_cnt,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, S_RD, S_DEC, S_FET, S_OUT, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNTWIDTH-1:0]   cnt_q, cnt_d;
    logic [CNTWIDTH-1:0]   err_q, err_d;
    logic [ADDR-1:0]       last_q, last_d;
    logic                  last_v_q, last_v_d;
    logic                  dir_q, dir_d;
    logic [ADDR-1:0]       addr_q, addr_d;
    logic [PIXWIDTH-1:0]   pix_a_q, pix_a_d;
    logic [PIXWIDTH-1:0]   pix_b_q, pix_b_d;
    logic [PIXWIDTH-1:0]   diff_q, diff_d;
    logic                  adv;
    logic [PIXWIDTH-1:0]   pa, pb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        last_d   = last_q;
        last_v_d = last_v_q;
        dir_d    = dir_q;
        addr_d   = addr_q;
        pix_a_d  = pix_a_q;
        pix_b_d  = pix_b_q;
        diff_d   = diff_q;
        sload    = 1'b0;
        saddr    = '0;
        fload    = 1'b0;
        faddr    = '0;
        adv      = 1'b0;
        pa       = fdata[DATAWIDTH-1 -: PIXWIDTH];
        pb       = fdata[PIXWIDTH-1:0];
        case (state_q)
            IDLE: if (enable) state_d = S_RD;
            S_RD: begin
                sload   = 1'b1;
                saddr   = ADDR'(cnt_q);
                state_d = S_DEC;
            end
            S_DEC: begin
                if (|sdata[DATAWIDTH-2:ADDR]) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    adv = 1'b1;
                end else if (SKIP_DUP != 0 && last_v_q && last_q == sdata[ADDR-1:0]) begin
                    adv = 1'b1;
                end else begin
                    fload   = 1'b1;
                    faddr   = sdata[ADDR-1:0];
                    dir_d   = sdata[DATAWIDTH-1];
                    addr_d  = sdata[ADDR-1:0];
                    state_d = S_FET;
                end
            end
            S_FET: begin
                pix_a_d = pa;
                pix_b_d = pb;
                diff_d  = (pa >= pb) ? pa - pb : pb - pa;
                state_d = S_OUT;
            end
            S_OUT: if (out_ready) begin
                last_d   = addr_q;
                last_v_d = 1'b1;
                adv      = 1'b1;
            end
            DONE: if (!enable) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        // The counter parks at ENTRIES-1 so saddr can never wrap.
        if (adv) begin
            if (cnt_q == CNTWIDTH'(ENTRIES-1)) begin
                state_d = DONE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= '0;
            last_q   <= '0;
            last_v_q <= 1'b0;
            dir_q    <= 1'b0;
            addr_q   <= '0;
            pix_a_q  <= '0;
            pix_b_q  <= '0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            last_q   <= last_d;
            last_v_q <= last_v_d;
            dir_q    <= dir_d;
            addr_q   <= addr_d;
            pix_a_q  <= pix_a_d;
            pix_b_q  <= pix_b_d;
            diff_q   <= diff_d;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign done      = (state_q == DONE);
    assign out_dir   = dir_q;
    assign out_addr  = addr_q;
    assign out_pix_a = pix_a_q;
    assign out_pix_b = pix_b_q;
    assign out_diff  = diff_q;
    assign err_cnt   = err_q;
endmodule
